// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: shared scan-state type and cell-vector helpers for the LED matrix scanner
package led_matrix_pkg;
    localparam int MAX_N = 32;
    typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} scan_state_t;
    typedef logic [MAX_N*MAX_N-1:0] cells_t;
    typedef logic [MAX_N-1:0] row_t;
    // columns of row r from a flat n x n cell vector (cells[r*n+c]); upper bits are don't-care
    function automatic row_t row_slice(cells_t cells, int n, int r);
        return row_t'(cells >> (r * n));
    endfunction
endpackage

// File: rtl/led_matrix_scanner_buffer.sv
// frame_double_buffer: pending/active frame storage with valid/ready intake and frame-boundary swap
module frame_double_buffer
    import led_matrix_pkg::*;
#(
    parameter int N  = 8,
    parameter int RW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*N-1:0] data_i,
    input  logic           valid_i,
    output logic           ready_o,
    input  logic           swap_i,
    input  logic [RW-1:0]  row_i,
    output logic [N-1:0]   slice_o
);
    logic [N*N-1:0] pending_q, pending_d, active_q, active_d;
    logic           full_q, full_d;
    // a swap only fires with pending full, an intake only with it empty, so the two never collide
    always_comb begin
        pending_d = pending_q;
        active_d  = active_q;
        full_d    = full_q;
        if (swap_i && full_q) begin
            active_d = pending_q;
            full_d   = 1'b0;
        end
        if (valid_i && !full_q) begin
            pending_d = data_i;
            full_d    = 1'b1;
        end
    end
    // buffer registers; reset discards any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            active_q  <= '0;
            full_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            active_q  <= active_d;
            full_q    <= full_d;
        end
    end
    assign ready_o = ~full_q;
    // slice taken from the post-swap frame so the first row of a new frame is already correct
    assign slice_o = N'(row_slice(cells_t'(active_d), N, int'(row_i)));
endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: row-multiplexed N x N LED matrix driver with tear-free double buffering
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int N            = 8,
    parameter int DIVIDER      = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*N-1:0] frame_data,
    input  logic           frame_valid,
    output logic           frame_ready,
    output logic [N-1:0]   rows,
    output logic [N-1:0]   cols,
    output logic           frame_done
);
    localparam int CMAX = (DIVIDER > BLANK_CYCLES) ? DIVIDER : BLANK_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int RW   = $clog2(N);
    localparam logic [CW-1:0] DRV_LAST = CW'(DIVIDER - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);
    scan_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] row_q, row_d;
    logic          lead_q, lead_d;
    logic          wrap;
    logic [N-1:0]  rows_q, rows_d, cols_q, cols_d, slice;
    logic          done_q;
    frame_double_buffer #(.N(N), .RW(RW)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (frame_data),
        .valid_i (frame_valid),
        .ready_o (frame_ready),
        .swap_i  (wrap),
        .row_i   (row_d),
        .slice_o (slice)
    );
    // phase sequencing: dwell counter counts down, the row advances on entry to each DRIVE
    // except the one ending the post-reset lead-in blank, which starts row 0 in place
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 1'b1;
        row_d   = row_q;
        lead_d  = lead_q && (cnt_q != '0);
        wrap    = 1'b0;
        if (cnt_q == '0) begin
            if (state_q == DRIVE && BLANK_CYCLES != 0) begin
                state_d = BLANK;
                cnt_d   = BLK_LAST;
            end else begin
                state_d = DRIVE;
                cnt_d   = DRV_LAST;
                if (!lead_q) begin
                    wrap  = (row_q == ROW_LAST);
                    row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end
            end
        end
    end
    // output decode from the next phase so the drive pins are plain registers
    always_comb begin
        rows_d = (state_d == DRIVE) ? (N'(1) << row_d) : '0;
        cols_d = (state_d == DRIVE) ? ~slice : '1;
    end
    // scan state and registered matrix outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BLANK;
            cnt_q   <= BLK_LAST;
            row_q   <= '0;
            lead_q  <= 1'b1;
            rows_q  <= '0;
            cols_q  <= '1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            lead_q  <= lead_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            done_q  <= wrap;
        end
    end
    assign rows       = rows_q;
    assign cols       = cols_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: randomized bench comparing two scanner builds against a frame-timing model
module tb_led_matrix_scanner;
    localparam int N  = 8;
    localparam int D  = 4;
    localparam int NN = N * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NN-1:0] data  [2];
    logic          valid [2];
    logic          ready [2];
    logic          done  [2];
    logic [N-1:0]  rows  [2];
    logic [N-1:0]  cols  [2];

    always #5 clk = ~clk;

    led_matrix_scanner #(.N(N), .DIVIDER(D), .BLANK_CYCLES(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .frame_data(data[0]), .frame_valid(valid[0]),
        .frame_ready(ready[0]), .rows(rows[0]), .cols(cols[0]), .frame_done(done[0])
    );
    led_matrix_scanner #(.N(N), .DIVIDER(D), .BLANK_CYCLES(0)) u_b0 (
        .clk(clk), .rst_n(rst_n), .frame_data(data[1]), .frame_valid(valid[1]),
        .frame_ready(ready[1]), .rows(rows[1]), .cols(cols[1]), .frame_done(done[1])
    );

    int passed = 0;
    int total  = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // reference model: the display is a pure function of cycles since release plus the frame stores
    int            blk [2] = '{1, 0};
    logic [NN-1:0] m_act [2];
    logic [NN-1:0] m_pend [2];
    logic          m_full [2];
    logic [NN-1:0] recon [2];
    int            last_done [2];
    int            k;
    int            mode;
    logic          pulse;
    logic          acc_last;
    logic [NN-1:0] ctr;

    function automatic int lead(int i);
        return (blk[i] == 0) ? 1 : blk[i];
    endfunction

    function automatic int per(int i);
        return N * (D + blk[i]);
    endfunction

    function automatic bit at_boundary(int i, int kk);
        return kk > lead(i) && ((kk - lead(i)) % per(i)) == 0;
    endfunction

    function automatic int drive_row(int i);
        int f;
        if (k < lead(i)) return -1;
        f = (k - lead(i)) % per(i);
        return ((f % (D + blk[i])) < D) ? f / (D + blk[i]) : -1;
    endfunction

    function automatic logic [NN-1:0] checkerboard();
        logic [NN-1:0] v;
        for (int r = 0; r < N; r++) v[r*N +: N] = (r % 2 == 0) ? 8'hAA : 8'h55;
        return v;
    endfunction

    task automatic model_reset();
        k = 0;
        acc_last = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_act[i] = '0;
            m_pend[i] = '0;
            m_full[i] = 1'b0;
            recon[i] = '0;
            last_done[i] = -1;
        end
        data[1] = {$urandom, $urandom};
    endtask

    task automatic check_reset(string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_rows%0d", tag, i), 64'(rows[i]), 64'(0));
            check($sformatf("%s_cols%0d", tag, i), 64'(cols[i]), 64'(8'hFF));
            check($sformatf("%s_ready%0d", tag, i), 64'(ready[i]), 64'(1));
            check($sformatf("%s_done%0d", tag, i), 64'(done[i]), 64'(0));
        end
    endtask

    task automatic check_outputs(int i);
        int r;
        logic [N-1:0] er, ec;
        r  = drive_row(i);
        er = (r >= 0) ? N'(1) << r : '0;
        ec = (r >= 0) ? ~m_act[i][r*N +: N] : '1;
        check($sformatf("rows%0d k=%0d", i, k), 64'(rows[i]), 64'(er));
        check($sformatf("cols%0d k=%0d", i, k), 64'(cols[i]), 64'(ec));
        check($sformatf("done%0d k=%0d", i, k), 64'(done[i]), 64'(at_boundary(i, k)));
        check($sformatf("ready%0d k=%0d", i, k), 64'(ready[i]), 64'(!m_full[i]));
        if (rows[i] != '0 && $onehot(rows[i])) recon[i][$clog2(rows[i])*N +: N] = ~cols[i];
        if (k >= lead(i) && (k - lead(i)) % per(i) == per(i) - 1)
            check($sformatf("frame%0d k=%0d", i, k), 64'(recon[i]), 64'(m_act[i]));
        if (done[i]) begin
            if (last_done[i] >= 0) check($sformatf("gap%0d", i), 64'(k - last_done[i]), 64'(per(i)));
            last_done[i] = k;
        end
    endtask

    task automatic pick_inputs();
        if (!(valid[0] && !acc_last)) begin
            if (mode == 1) begin
                valid[0] = ($urandom_range(0, 3) == 0);
                data[0]  = {$urandom, $urandom};
            end else if (mode == 2) begin
                valid[0] = 1'b1;
                data[0]  = ctr;
                ctr      = ctr + 1;
            end else if (mode == 3) begin
                valid[0] = pulse;
                data[0]  = checkerboard();
                pulse    = 1'b0;
            end else if (mode == 4) begin
                valid[0] = at_boundary(0, k) && !m_full[0];
                data[0]  = {$urandom, $urandom};
            end else begin
                valid[0] = 1'b0;
            end
        end
        valid[1] = (k == 0);
    endtask

    task automatic model_edge();
        logic acc;
        for (int i = 0; i < 2; i++) begin
            acc = valid[i] && !m_full[i];
            if (i == 0) acc_last = acc;
            if (at_boundary(i, k + 1) && m_full[i]) begin
                m_act[i]  = m_pend[i];
                m_full[i] = 1'b0;
            end
            if (acc) begin
                m_pend[i] = data[i];
                m_full[i] = 1'b1;
            end
        end
        k++;
    endtask

    task automatic cycle();
        check_outputs(0);
        check_outputs(1);
        pick_inputs();
        model_edge();
        @(negedge clk);
    endtask

    task automatic run(int n);
        repeat (n) cycle();
    endtask

    initial begin
        logic found;
        mode = 0;
        pulse = 1'b0;
        ctr = 64'h1;
        valid[0] = 1'b0;
        valid[1] = 1'b0;
        data[0] = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        model_reset();
        run(90);
        mode = 3;
        pulse = 1'b1;
        run(100);
        mode = 1;
        run(400);
        mode = 2;
        run(300);
        mode = 0;
        run(90);
        mode = 4;
        run(200);
        mode = 2;
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            if (drive_row(0) == 5 && m_full[0]) found = 1'b1;
            else cycle();
        end
        check("row5_reached", 64'(found), 64'(1));
        #2 rst_n = 1'b0;
        #1 check_reset("async");
        mode = 0;
        valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("held");
        rst_n = 1'b1;
        model_reset();
        run(100);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
